rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
// PURPOSE
//  Shares one data/instruction memory port between the instruction-fetch (I) and load/store (D) requesters.
//  Sits between rv32 core(s) and a single-ported memory with variable latency.
//  Serialises requests: one outstanding transaction. Routes each response to its owner.
//  A timeout counter converts a hung memory into an error response.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  cycles from grant to forced error response; legal range 2..65535
// PORTS
//  clk        in   1   clock
//  reset_n    in   1   synchronous active-low reset
//  i_req      in   1   fetch request; held with i_addr until i_gnt
//  i_addr     in   AW  fetch address
//  i_gnt      out  1   fetch request accepted this cycle
//  i_rvalid   out  1   one-cycle pulse: fetch response valid
//  i_rdata    out  DW  fetch data; valid with i_rvalid
//  i_err      out  1   fetch timed out; valid with i_rvalid
//  d_req      in   1   load/store request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  load/store address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   load/store request accepted this cycle
//  d_rvalid   out  1   one-cycle pulse: load/store response valid (store = ack)
//  d_rdata    out  DW  load data; valid with d_rvalid
//  d_err      out  1   load/store timed out; valid with d_rvalid
//  mem_req    out  1   memory request; held until mem_ready
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_ready  in   1   memory accepts mem_req this cycle
//  mem_rvalid in   1   memory response, reads and writes; earliest one cycle after mem_ready
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=IDLE, timeout counter=0, last owner=I.
//    All outputs 0, including rdata. An in-flight transaction is abandoned.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: if any req, the winner's x_gnt=1 combinationally. On the edge, latch we/addr/wdata and owner (I fetch: we=0, wdata=0), clear counter, go to ISSUE.
//    ISSUE: mem_req=1 with the latched fields. On mem_ready, go to WAIT.
//    WAIT: mem_req=0. On mem_rvalid, the owner's x_rvalid=1 next cycle, x_rdata=mem_rdata, x_err=0. Go to IDLE.
//  - Counter increments every cycle in ISSUE and WAIT. When it reaches TIMEOUT-1 with no mem_rvalid:
//    owner's x_rvalid=1 and x_err=1 next cycle, x_rdata=0, go to IDLE.
//    If mem_rvalid arrives in that same cycle, it wins (normal response, no error).
//  - mem_rvalid in IDLE or ISSUE is ignored. This covers late responses after a timeout or a reset.
//  - x_rdata/x_err hold their last value between pulses; x_rvalid is never high for both owners.
//  - Latency: gnt cycle -> >=1 ISSUE -> >=1 WAIT -> rvalid. Minimum 3 cycles grant-to-rvalid with zero-wait memory.
//    A new grant may occur in the rvalid cycle (state is IDLE), so back-to-back throughput is 1 transaction per 3 cycles.
//  - mem_addr/mem_we/mem_wdata are driven from the latched registers; 0 when not in ISSUE.
// CONFIGURATION
//  RV32_ARB_RR_EN defined: round-robin. On simultaneous i_req and d_req, grant the owner not granted last.
//    A single requester is always granted.
//  RV32_ARB_RR_EN undefined: fixed priority, D always beats I. The last-owner register is not built.
// STRUCTURE
//  Shared package rv32_arb_pkg: FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2),
//    owner encoding (OWN_I=1'b0, OWN_D=1'b1), timeout-counter width function.
//  Sub-module rv32_arb_pick: 2-way picker (i_req, d_req, last_owner -> gnt_i, gnt_d, owner).
//    Holds the RV32_ARB_RR_EN ifdef.
// TESTING
//  1. Reset mid-WAIT: d load granted, reset_n=0 one cycle -> all outputs 0, state IDLE;
//     later mem_rvalid ignored, no d_rvalid.
//  2. Single fetch, zero-wait memory: i_req, i_addr=0x100, mem_rdata=0x00500093 ->
//     i_gnt cycle 0, mem_req cycle 1, i_rvalid=1 cycle 3 with i_rdata=0x00500093, i_err=0.
//  3. Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready delayed 2 cycles ->
//     mem_req held 3 cycles with those fields, d_rvalid after mem_rvalid, i_rvalid stays 0.
//  4. Contention: i_req and d_req both high for 4 transactions ->
//     RV32_ARB_RR_EN: D,I,D,I grant order (last owner=I after reset);
//     without the macro: D,D,D,D and I never granted.
//  5. Timeout with TIMEOUT=8: mem_ready=1, mem_rvalid never ->
//     d_rvalid=1, d_err=1, d_rdata=0 exactly 8 cycles after grant.
//     A mem_rvalid two cycles later produces no response.
//  6. Boundary: mem_rvalid in the same cycle the counter hits TIMEOUT-1 -> normal response, err=0.

Source files
------------

// File: rtl/rv32_arb_pkg.sv
// Shared encodings for the rv32 memory arbiter: FSM states, requester owner
// and the width of the grant-to-error timeout counter.
package rv32_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // The counter must hold values up to TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rv32_arb_pick.sv
// Two-way request picker. With RV32_ARB_RR_EN defined it alternates owners on
// contention; otherwise the load/store side always wins.
module rv32_arb_pick
    import rv32_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   gnt_i,
    output logic   gnt_d,
    output owner_e owner
);

`ifdef RV32_ARB_RR_EN
    always_comb begin
        owner = OWN_I;
        if (i_req && d_req) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end
`else
    // Fixed priority has no use for history.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        owner = d_req ? OWN_D : OWN_I;
    end
`endif

    assign gnt_i = i_req && (owner == OWN_I);
    assign gnt_d = d_req && (owner == OWN_D);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one variable-latency memory port between fetch (I) and load/store (D),
// one transaction at a time, with a timeout that turns a hung memory into an error.
// Arbitration policy selected by RV32_ARB_RR_EN (see rv32_arb_pick).
module rv32_mem_arbiter
    import rv32_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = cnt_width(TIMEOUT);
    // Firing one count early lands the error pulse exactly TIMEOUT cycles after grant.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        pick_owner;
    logic          pick_gnt_i, pick_gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic          d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic          rsp_fire, rsp_err, timeout_hit;

    rv32_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (owner_q),
        .gnt_i      (pick_gnt_i),
        .gnt_d      (pick_gnt_d),
        .owner      (pick_owner)
    );

    assign i_gnt = reset_n && (state_q == IDLE) && pick_gnt_i;
    assign d_gnt = reset_n && (state_q == IDLE) && pick_gnt_d;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_err_d    = i_err_q;
        d_err_d    = d_err_q;
        rsp_fire   = 1'b0;
        rsp_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_gnt || d_gnt) begin
                    owner_d = pick_owner;
                    we_d    = d_gnt ? d_we : 1'b0;
                    addr_d  = d_gnt ? d_addr : i_addr;
                    wdata_d = d_gnt ? d_wdata : '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else if (mem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A real response beats a simultaneous timeout.
                if (mem_rvalid) begin
                    rsp_fire = 1'b1;
                end else if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp_fire) begin
            state_d = IDLE;
            if (owner_q == OWN_D) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = rsp_err ? '0 : mem_rdata;
                d_err_d    = rsp_err;
            end else begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = rsp_err ? '0 : mem_rdata;
                i_err_d    = rsp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_err_q    <= i_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter (TIMEOUT=8): behavioural memory, response scoreboard,
// a table of single transactions and hand-written corner-case sequences.
module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    rv32_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own_d;
        logic [31:0] data;
        bit          err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gcyc;
        int          lat;
    } sb_t;

    typedef struct {
        bit          i_req;
        logic [31:0] i_addr;
        bit          d_req;
        bit          d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          rdy;
        int          rsp;
        bit          exp_d;
    } vec_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_rvalid = 0;
    bit          last_gnt_d;
    // Overrides for the next pushed expectation (timeouts, injected data).
    bit          nxt_ovr = 0, nxt_err = 0;
    logic [31:0] nxt_data = '0;
    int          nxt_lat = 0;
    // Memory model state.
    int          rdy_dly = 0, rdy_left = 0, rsp_dly = 1, rsp_left = 0;
    bit          hang = 0, pend = 0, pend_we = 0, inject = 0;
    logic [31:0] pend_addr = '0, inject_data = '0;
    int          req_len = 0, last_req_len = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cfg_mem(input int rdy, input int rsp, input bit hg);
        rdy_dly = rdy; rdy_left = rdy; rsp_dly = rsp; hang = hg;
    endtask

    task automatic check_rsp();
        sb_t e;
        if (i_rvalid && d_rvalid) begin
            n_checks++; n_errors++;
            $display("FAIL both_rvalid: i_rvalid and d_rvalid high together (cycle %0d)", cyc);
        end
        if (i_rvalid || d_rvalid) begin
            n_rvalid++;
            if (sb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_rvalid: i=%0b d=%0b with nothing outstanding (cycle %0d)",
                         i_rvalid, d_rvalid, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rsp_owner_d", d_rvalid, e.own_d);
                check("rsp_rdata", e.own_d ? d_rdata : i_rdata, e.data);
                check("rsp_err", e.own_d ? d_err : i_err, e.err);
                if (e.lat != 0) check("rsp_latency", cyc - e.gcyc, e.lat);
                $display("txn cycle=%0d owner=%s addr=0x%08h we=%0b rdata=0x%08h err=%0b",
                         cyc, d_rvalid ? "D" : "I", e.addr, e.we,
                         d_rvalid ? d_rdata : i_rdata, d_rvalid ? d_err : i_err);
            end
        end
    endtask

    task automatic mem_model();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        if (inject) begin
            mem_rvalid = 1'b1;
            mem_rdata  = inject_data;
            inject     = 0;
        end else if (pend) begin
            if (rsp_left <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_we ? 32'h0 : mem_fn(pend_addr);
                pend       = 0;
            end else begin
                rsp_left--;
            end
        end
        if (mem_req) begin
            req_len++;
            if (sb_q.size() > 0) begin
                check("mem_we", mem_we, sb_q[0].we);
                check("mem_addr", mem_addr, sb_q[0].addr);
                check("mem_wdata", mem_wdata, sb_q[0].wdata);
            end
            if (rdy_left > 0) begin
                rdy_left--;
            end else begin
                mem_ready    = 1'b1;
                last_req_len = req_len;
                req_len      = 0;
                rdy_left     = rdy_dly;
                if (!hang) begin
                    pend = 1; pend_addr = mem_addr; pend_we = mem_we; rsp_left = rsp_dly;
                end
            end
        end else begin
            check("mem_idle_zero", |{mem_we, mem_addr, mem_wdata}, 1'b0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_rsp();
        mem_model();
    endtask

    task automatic sample_gnt(output bit got);
        sb_t e;
        got = 0;
        if (i_gnt && d_gnt) begin
            n_checks++; n_errors++;
            $display("FAIL dual_gnt: i_gnt and d_gnt high together (cycle %0d)", cyc);
        end
        if (i_gnt || d_gnt) begin
            got        = 1;
            last_gnt_d = d_gnt;
            e.own_d    = d_gnt;
            e.we       = d_gnt ? d_we : 1'b0;
            e.addr     = d_gnt ? d_addr : i_addr;
            e.wdata    = d_gnt ? d_wdata : 32'h0;
            e.data     = nxt_ovr ? nxt_data : (e.we ? 32'h0 : mem_fn(e.addr));
            e.err      = nxt_err;
            e.gcyc     = cyc;
            e.lat      = nxt_lat;
            sb_q.push_back(e);
            nxt_ovr = 0; nxt_err = 0; nxt_lat = 0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: no response within 60 cycles", name);
            sb_q.delete();
        end
    endtask

    task automatic run_txn(input vec_t v, input string name);
        bit got;
        int n = 0;
        cfg_mem(v.rdy, v.rsp, 0);
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        #1 sample_gnt(got);
        while (!got && n < 20) begin
            tick();
            #1 sample_gnt(got);
            n++;
        end
        check({name, "_granted"}, got, 1'b1);
        if (got) check({name, "_gnt_owner_d"}, last_gnt_d, v.exp_d);
        tick();
        i_req = 0; d_req = 0;
        wait_done(name);
    endtask

    task automatic do_reset();
        reset_n = 0;
        i_req = 0; d_req = 0;
        tick();
        tick();
        sb_q.delete();
        pend = 0; inject = 0; req_len = 0;
        reset_n = 1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_req, mem_we}, '0);
        check({name, "_i_rdata"}, i_rdata, '0);
        check({name, "_d_rdata"}, d_rdata, '0);
        check({name, "_mem_addr"}, mem_addr, '0);
        check({name, "_mem_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit   got;
        bit   order[4];
        int   ng;
        int   rv0;
        bit   exp_order[4];

        vecs[0] = '{1, 32'h0000_0104, 0, 0, 32'h0,         32'h0,         0, 1, 0};
        vecs[1] = '{0, 32'h0,         1, 0, 32'h0000_3000, 32'h0,         1, 2, 1};
        vecs[2] = '{0, 32'h0,         1, 1, 32'h0000_3004, 32'h1234_5678, 0, 4, 1};
        vecs[3] = '{1, 32'h0000_0200, 0, 0, 32'h0,         32'h0,         3, 1, 0};
        vecs[4] = '{0, 32'h0,         1, 0, 32'hFFFF_FFFC, 32'h0,         0, 1, 1};
        vecs[5] = '{0, 32'h0,         1, 1, 32'h0,         32'hFFFF_FFFF, 2, 3, 1};

        reset_n = 0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        tick(); tick(); tick();
        check_all_zero("reset");
        reset_n = 1;
        tick();

        // Single fetch, zero-wait memory: rvalid three cycles after grant.
        cfg_mem(0, 1, 0);
        i_req = 1; i_addr = 32'h0000_0100;
        nxt_lat = 3;
        #1 sample_gnt(got);
        check("t2_i_gnt", got, 1'b1);
        tick();
        i_req = 0;
        check("t2_mem_req_c1", mem_req, 1'b1);
        wait_done("t2");

        // Store with mem_ready held off two cycles.
        cfg_mem(2, 1, 0);
        d_req = 1; d_we = 1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        nxt_lat = 5;
        #1 sample_gnt(got);
        check("t3_d_gnt", got, 1'b1);
        tick();
        d_req = 0;
        wait_done("t3");
        check("t3_req_len", last_req_len, 3);

        for (int k = 0; k < 6; k++) begin
            run_txn(vecs[k], $sformatf("vec%0d", k));
        end

        // Timeout: memory accepts but never answers; late response is dropped.
        cfg_mem(0, 1, 1);
        d_req = 1; d_we = 0; d_addr = 32'h0000_5000; d_wdata = 0;
        nxt_ovr = 1; nxt_data = 32'h0; nxt_err = 1; nxt_lat = 8;
        #1 sample_gnt(got);
        check("t5_d_gnt", got, 1'b1);
        tick();
        d_req = 0;
        wait_done("t5");
        rv0 = n_rvalid;
        tick();
        inject = 1; inject_data = 32'h1111_2222;
        tick(); tick(); tick(); tick();
        check("t5_late_ignored", n_rvalid - rv0, 0);

        // mem_rvalid in the very cycle the timeout would fire wins.
        cfg_mem(0, 1, 1);
        d_req = 1; d_we = 0; d_addr = 32'h0000_6000;
        nxt_ovr = 1; nxt_data = 32'hCAFE_F00D; nxt_err = 0; nxt_lat = 8;
        #1 sample_gnt(got);
        check("t6_d_gnt", got, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            d_req = 0;
        end
        inject = 1; inject_data = 32'hCAFE_F00D;
        wait_done("t6");

        // Reset while waiting for the memory; its late response is ignored.
        cfg_mem(0, 1, 1);
        d_req = 1; d_we = 0; d_addr = 32'h0000_4000; d_wdata = 0;
        #1 sample_gnt(got);
        check("t1_d_gnt", got, 1'b1);
        tick();
        d_req = 0;
        tick();
        reset_n = 0;
        tick();
        check_all_zero("t1_reset");
        sb_q.delete();
        reset_n = 1;
        rv0 = n_rvalid;
        inject = 1; inject_data = 32'h3333_4444;
        tick(); tick(); tick(); tick();
        check("t1_no_rvalid", n_rvalid - rv0, 0);
        run_txn(vecs[0], "t1_after");

        // Contention straight after reset.
        do_reset();
        cfg_mem(0, 1, 0);
        i_req = 1; i_addr = 32'h0000_0400;
        d_req = 1; d_we = 0; d_addr = 32'h0000_0500; d_wdata = 0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1 sample_gnt(got);
            if (got) begin
                order[ng] = last_gnt_d;
                ng++;
            end
            tick();
        end
        i_req = 0; d_req = 0;
        wait_done("t4");
        check("t4_grants", ng, 4);
`ifdef RV32_ARB_RR_EN
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
`else
        exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1; exp_order[3] = 1;
`endif
        for (int k = 0; k < 4; k++) begin
            if (k < ng) check($sformatf("t4_order%0d_d", k), order[k], exp_order[k]);
        end

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
